// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Arbitrates register-file writeback between the ALU (requester A) and the
//   MUL/DIV unit (requester B). One requester is granted per cycle. When both
//   are valid, the one that did not win the last transfer is granted. The
//   granted request is registered and presented to the register file for
//   exactly one cycle. B may also write R15 through the dedicated R15 port.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   a_valid/a_ready     ALU handshake (a_ready is combinational)
//   a_dst, a_data       ALU destination index and data
//   b_valid/b_ready     MUL/DIV handshake (b_ready is combinational)
//   b_dst, b_data       MUL/DIV destination index and low result
//   b_wr_r15            MUL/DIV request also writes R15
//   b_r15_data          MUL/DIV high result for R15
//   wr, regDst,
//   regDstData          registered main write port
//   wrR15, regR15Data   registered R15 write port
//   conflict_cnt        saturating count of cycles with both requests valid
// ---------------------------------------------------------------------------
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_dst,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_dst,
    input  logic [15:0] b_data,
    input  logic        b_wr_r15,
    input  logic [15:0] b_r15_data,
    output logic        wr,
    output logic [3:0]  regDst,
    output logic [15:0] regDstData,
    output logic        wrR15,
    output logic [15:0] regR15Data,
    output logic [7:0]  conflict_cnt
);

    // 1: last transfer went to B (reset value, so A wins the first conflict)
    logic lastGrantB;
    logic grantA;
    logic grantB;
    logic bCollision;

    always_comb begin
        grantA = ~rst & a_valid & (~b_valid | lastGrantB);
        grantB = ~rst & b_valid & (~a_valid | ~lastGrantB);
    end

    assign a_ready = grantA;
    assign b_ready = grantB;

    // A B-write to R15 through both ports at once: the R15 port carries the
    // high result and the low result is dropped.
    assign bCollision = b_wr_r15 & (b_dst == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr           <= 1'b0;
            wrR15        <= 1'b0;
            regDst       <= 4'h0;
            regDstData   <= 16'h0000;
            regR15Data   <= 16'h0000;
            lastGrantB   <= 1'b1;
            conflict_cnt <= 8'h00;
        end else begin
            wr    <= 1'b0;
            wrR15 <= 1'b0;

            if (grantA) begin
                wr         <= 1'b1;
                regDst     <= a_dst;
                regDstData <= a_data;
                lastGrantB <= 1'b0;
            end else if (grantB) begin
                lastGrantB <= 1'b1;
                if (!bCollision) begin
                    wr         <= 1'b1;
                    regDst     <= b_dst;
                    regDstData <= b_data;
                end
                if (b_wr_r15) begin
                    wrR15      <= 1'b1;
                    regR15Data <= b_r15_data;
                end
            end

            if (a_valid && b_valid && (conflict_cnt != 8'hFF))
                conflict_cnt <= conflict_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed testbench for rf_wb_arbiter. Inputs are driven and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_dst;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_dst;
    logic [15:0] b_data;
    logic        b_wr_r15;
    logic [15:0] b_r15_data;
    logic        wr;
    logic [3:0]  regDst;
    logic [15:0] regDstData;
    logic        wrR15;
    logic [15:0] regR15Data;
    logic [7:0]  conflict_cnt;

    int nChecks = 0;
    int nPass   = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
        .b_wr_r15(b_wr_r15), .b_r15_data(b_r15_data),
        .wr(wr), .regDst(regDst), .regDstData(regDstData),
        .wrR15(wrR15), .regR15Data(regR15Data), .conflict_cnt(conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idleInputs();
        a_valid = 0; b_valid = 0; b_wr_r15 = 0;
    endtask

    // Reset pulse placed between a falling and the next rising edge.
    task automatic pulseReset();
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1; b_valid = 1; a_dst = 4'h7; a_data = 16'h1234;
        #3;
        nChecks++; if (wr !== 1'b0) $display("FAIL reset_wr got=%0b exp=0", wr); else nPass++;
        nChecks++; if (wrR15 !== 1'b0) $display("FAIL reset_wrR15 got=%0b exp=0", wrR15); else nPass++;
        nChecks++; if (regDst !== 4'h0) $display("FAIL reset_regDst got=%h exp=0", regDst); else nPass++;
        nChecks++; if (regDstData !== 16'h0000) $display("FAIL reset_regDstData got=%h exp=0000", regDstData); else nPass++;
        nChecks++; if (regR15Data !== 16'h0000) $display("FAIL reset_regR15Data got=%h exp=0000", regR15Data); else nPass++;
        nChecks++; if (conflict_cnt !== 8'h00) $display("FAIL reset_cnt got=%h exp=00", conflict_cnt); else nPass++;
        nChecks++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got=%0b exp=0", a_ready); else nPass++;
        nChecks++; if (b_ready !== 1'b0) $display("FAIL reset_b_ready got=%0b exp=0", b_ready); else nPass++;
        @(negedge clk);
        nChecks++; if (wr !== 1'b0) $display("FAIL reset_held_wr got=%0b exp=0", wr); else nPass++;
        idleInputs();
        rst = 1'b0;
    endtask

    task automatic test_single_a();
        @(negedge clk);
        a_valid = 1; a_dst = 4'h1; a_data = 16'hCCCC;
        #1;
        nChecks++; if (a_ready !== 1'b1) $display("FAIL sa_a_ready got=%0b exp=1", a_ready); else nPass++;
        nChecks++; if (b_ready !== 1'b0) $display("FAIL sa_b_ready got=%0b exp=0", b_ready); else nPass++;
        @(negedge clk);
        a_valid = 0; a_data = 16'h0BAD;
        nChecks++; if (wr !== 1'b1) $display("FAIL sa_wr got=%0b exp=1", wr); else nPass++;
        nChecks++; if (regDst !== 4'h1) $display("FAIL sa_regDst got=%h exp=1", regDst); else nPass++;
        nChecks++; if (regDstData !== 16'hCCCC) $display("FAIL sa_data got=%h exp=CCCC", regDstData); else nPass++;
        nChecks++; if (wrR15 !== 1'b0) $display("FAIL sa_wrR15 got=%0b exp=0", wrR15); else nPass++;
        @(negedge clk);
        nChecks++; if (wr !== 1'b0) $display("FAIL sa_wr_drop got=%0b exp=0", wr); else nPass++;
        nChecks++; if (regDstData !== 16'hCCCC) $display("FAIL sa_data_hold got=%h exp=CCCC", regDstData); else nPass++;
    endtask

    task automatic test_single_b_r15();
        @(negedge clk);
        b_valid = 1; b_dst = 4'h2; b_data = 16'hF0F0; b_wr_r15 = 1; b_r15_data = 16'h0F0F;
        #1;
        nChecks++; if (b_ready !== 1'b1) $display("FAIL sb_b_ready got=%0b exp=1", b_ready); else nPass++;
        @(negedge clk);
        idleInputs();
        nChecks++; if (wr !== 1'b1) $display("FAIL sb_wr got=%0b exp=1", wr); else nPass++;
        nChecks++; if (regDst !== 4'h2) $display("FAIL sb_regDst got=%h exp=2", regDst); else nPass++;
        nChecks++; if (regDstData !== 16'hF0F0) $display("FAIL sb_data got=%h exp=F0F0", regDstData); else nPass++;
        nChecks++; if (wrR15 !== 1'b1) $display("FAIL sb_wrR15 got=%0b exp=1", wrR15); else nPass++;
        nChecks++; if (regR15Data !== 16'h0F0F) $display("FAIL sb_r15data got=%h exp=0F0F", regR15Data); else nPass++;
        @(negedge clk);
        nChecks++; if (wrR15 !== 1'b0) $display("FAIL sb_wrR15_drop got=%0b exp=0", wrR15); else nPass++;
        nChecks++; if (regR15Data !== 16'h0F0F) $display("FAIL sb_r15_hold got=%h exp=0F0F", regR15Data); else nPass++;
    endtask

    task automatic test_conflict();
        logic [3:0] expDst [4];
        logic [15:0] expData [4];
        logic expA [4];
        expDst  = '{4'h3, 4'h4, 4'h3, 4'h4};
        expData = '{16'hAAAA, 16'hBBBB, 16'hAAAA, 16'hBBBB};
        expA    = '{1'b1, 1'b0, 1'b1, 1'b0};
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                nChecks++; if (regDst !== expDst[i-1]) $display("FAIL cf_regDst[%0d] got=%h exp=%h", i-1, regDst, expDst[i-1]); else nPass++;
                nChecks++; if (regDstData !== expData[i-1]) $display("FAIL cf_data[%0d] got=%h exp=%h", i-1, regDstData, expData[i-1]); else nPass++;
            end
            a_valid = 1; a_dst = 4'h3; a_data = 16'hAAAA;
            b_valid = 1; b_dst = 4'h4; b_data = 16'hBBBB; b_wr_r15 = 0;
            #1;
            nChecks++; if (a_ready !== expA[i]) $display("FAIL cf_a_ready[%0d] got=%0b exp=%0b", i, a_ready, expA[i]); else nPass++;
            nChecks++; if (b_ready !== !expA[i]) $display("FAIL cf_b_ready[%0d] got=%0b exp=%0b", i, b_ready, !expA[i]); else nPass++;
        end
        @(negedge clk);
        idleInputs();
        nChecks++; if (wr !== 1'b1) $display("FAIL cf_wr_last got=%0b exp=1", wr); else nPass++;
        nChecks++; if (regDst !== 4'h4) $display("FAIL cf_regDst[3] got=%h exp=4", regDst); else nPass++;
        nChecks++; if (conflict_cnt !== 8'd4) $display("FAIL cf_cnt got=%0d exp=4", conflict_cnt); else nPass++;
    endtask

    task automatic test_collision();
        @(negedge clk);
        b_valid = 1; b_dst = 4'hF; b_wr_r15 = 1; b_data = 16'h1111; b_r15_data = 16'h2222;
        @(negedge clk);
        idleInputs();
        nChecks++; if (wr !== 1'b0) $display("FAIL col_wr got=%0b exp=0", wr); else nPass++;
        nChecks++; if (wrR15 !== 1'b1) $display("FAIL col_wrR15 got=%0b exp=1", wrR15); else nPass++;
        nChecks++; if (regR15Data !== 16'h2222) $display("FAIL col_r15data got=%h exp=2222", regR15Data); else nPass++;
        nChecks++; if (regDstData !== 16'hBBBB) $display("FAIL col_data_hold got=%h exp=BBBB", regDstData); else nPass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  dstV  [4];
        logic [15:0] dataV [4];
        logic        useA  [4];
        dstV  = '{4'h5, 4'h6, 4'hF, 4'h8};
        dataV = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        useA  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                nChecks++; if (wr !== 1'b1) $display("FAIL b2b_wr[%0d] got=%0b exp=1", i-1, wr); else nPass++;
                nChecks++; if (regDst !== dstV[i-1]) $display("FAIL b2b_regDst[%0d] got=%h exp=%h", i-1, regDst, dstV[i-1]); else nPass++;
                nChecks++; if (regDstData !== dataV[i-1]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i-1, regDstData, dataV[i-1]); else nPass++;
                nChecks++; if (wrR15 !== 1'b0) $display("FAIL b2b_wrR15[%0d] got=%0b exp=0", i-1, wrR15); else nPass++;
            end
            idleInputs();
            if (i < 4) begin
                if (useA[i]) begin a_valid = 1; a_dst = dstV[i]; a_data = dataV[i]; end
                else begin b_valid = 1; b_dst = dstV[i]; b_data = dataV[i]; end
            end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        a_valid = 1; a_dst = 4'h9; a_data = 16'h5A5A;
        @(posedge clk);
        #1;
        a_valid = 0;
        nChecks++; if (wr !== 1'b1) $display("FAIL rm_wr_pre got=%0b exp=1", wr); else nPass++;
        rst = 1'b1;
        #1;
        nChecks++; if (wr !== 1'b0) $display("FAIL rm_wr got=%0b exp=0", wr); else nPass++;
        nChecks++; if (wrR15 !== 1'b0) $display("FAIL rm_wrR15 got=%0b exp=0", wrR15); else nPass++;
        nChecks++; if (regDst !== 4'h0) $display("FAIL rm_regDst got=%h exp=0", regDst); else nPass++;
        nChecks++; if (regDstData !== 16'h0000) $display("FAIL rm_data got=%h exp=0000", regDstData); else nPass++;
        nChecks++; if (regR15Data !== 16'h0000) $display("FAIL rm_r15data got=%h exp=0000", regR15Data); else nPass++;
        a_valid = 1; b_valid = 1;
        #1;
        nChecks++; if (a_ready !== 1'b0) $display("FAIL rm_a_ready got=%0b exp=0", a_ready); else nPass++;
        nChecks++; if (b_ready !== 1'b0) $display("FAIL rm_b_ready got=%0b exp=0", b_ready); else nPass++;
        @(posedge clk);
        #1;
        nChecks++; if (wr !== 1'b0) $display("FAIL rm_wr_held got=%0b exp=0", wr); else nPass++;
        nChecks++; if (conflict_cnt !== 8'h00) $display("FAIL rm_cnt got=%h exp=00", conflict_cnt); else nPass++;
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        pulseReset();
        @(negedge clk);
        a_valid = 1; b_valid = 1; a_dst = 4'h1; b_dst = 4'h2;
        for (int k = 1; k <= 305; k++) begin
            @(negedge clk);
            if (k == 254) begin
                nChecks++; if (conflict_cnt !== 8'hFE) $display("FAIL sat_254 got=%h exp=FE", conflict_cnt); else nPass++;
            end
            if (k == 255) begin
                nChecks++; if (conflict_cnt !== 8'hFF) $display("FAIL sat_255 got=%h exp=FF", conflict_cnt); else nPass++;
            end
            if (k == 300) begin
                nChecks++; if (conflict_cnt !== 8'hFF) $display("FAIL sat_300 got=%h exp=FF", conflict_cnt); else nPass++;
            end
        end
        idleInputs();
        @(negedge clk);
        nChecks++; if (conflict_cnt !== 8'hFF) $display("FAIL sat_hold got=%h exp=FF", conflict_cnt); else nPass++;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_dst = 0; a_data = 0;
        b_valid = 0; b_dst = 0; b_data = 0; b_wr_r15 = 0; b_r15_data = 0;
        test_reset();
        test_single_a();
        test_single_b_r15();
        test_conflict();
        test_collision();
        test_back_to_back();
        test_reset_midop();
        test_saturation();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
